jk_command_encoder: RTL and testbench
=====================================

Name: jk_command_encoder

Overview:
- Inverse companion of the JK flip-flop bank. Accepts a stream of target state vectors over a valid/ready handshake and emits per-bit J/K command vectors that drive WIDTH external JK flip-flops to the target.
- Keeps a shadow copy of the bank state to compute the commands.
- Provides a resync port, a saturating bit-change counter and a registered, backpressure-aware command output.
- Sits between control logic and a JK flip-flop bank.

Parameters:
- WIDTH, 8, number of JK flip-flops driven.
- RESET_VALUE, 0, WIDTH-bit shadow state after reset; must equal the bank's power-up state.
- USE_TOGGLE, 0, 1 = changing bits encoded as J=K=1 (toggle); 0 = J=1 to set, K=1 to clear.
- COUNTER_WIDTH, 16, width of the change counter.

Ports:
- clock  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- target_valid  input  1  target vector offered.
- target_ready  output  1  encoder accepts target this cycle.
- target_state  input  WIDTH  desired bank state.
- target_mask  input  WIDTH  1 = bit is don't-care (leave unchanged).
- sync_valid  input  1  load shadow from sync_state.
- sync_state  input  WIDTH  actual bank state for resynchronisation.
- command_valid  output  1  j/k vectors valid.
- command_ready  input  1  downstream consumes command this cycle.
- j  output  WIDTH  J inputs for bank.
- k  output  WIDTH  K inputs for bank.
- shadow_state  output  WIDTH  predicted bank state after all issued commands.
- change_count  output  COUNTER_WIDTH  saturating count of bits changed.
- idle  output  1  high when command_valid=0 and target_valid=0.

Behaviour:
- Reset (async, resetn=0): command_valid=0, j=0, k=0, shadow_state=RESET_VALUE, change_count=0. Outputs hold these values for the whole time resetn=0. First accept is possible on the first rising edge after release.
- Handshake:
  - target_ready = !sync_valid && (!command_valid || command_ready).
  - Accept happens when target_valid && target_ready.
  - Once command_valid=1, it and j/k stay stable until command_ready=1.
  - Throughput is one command per cycle under continuous ready.
  - Command appears registered, 1 cycle after accept.
- Per-bit encoding on accept, with s = shadow_state[i], t = target_state[i], m = target_mask[i]:
  - m=1 or t==s: j=0, k=0 (hold).
  - t=1, s=0: j=1, k=0; with USE_TOGGLE=1, j=1, k=1.
  - t=0, s=1: j=0, k=1; with USE_TOGGLE=1, j=1, k=1.
  - j=k=1 never occurs when USE_TOGGLE=0.
- Shadow update on accept: shadow_state <= (target_state & ~target_mask) | (shadow_state & target_mask). The update happens at the accept edge, not at downstream consumption, so back-to-back targets encode against the already-issued command.
- Accept with all bits holding: command still issued (command_valid=1, j=k=0) so the upstream ordering is preserved.
- change_count: on accept, add popcount(j|k) of the new command. Saturate at 2^COUNTER_WIDTH-1; never wraps.
- Command register drain:
  - If command_ready=1 and there is no new accept, command_valid <= 0 and j, k <= 0.
  - If command_ready=1 and there is an accept in the same cycle, the new command replaces the old one with no bubble.
- Resync: when sync_valid=1, shadow_state <= sync_state on that edge.
  - target_ready=0 that cycle, so sync has priority over target.
  - A pending command is unaffected and still drains.
  - change_count is unchanged.
  - The next accepted target encodes against the synced value.
- Reset mid-operation: a pending command is discarded (command_valid drops asynchronously). The shadow returns to RESET_VALUE; the bank must be reset concurrently.

Test Plan:
- Reset, WIDTH=8, RESET_VALUE=0, USE_TOGGLE=0; target 8'hA5, mask 0, command_ready=1 -> next cycle command_valid=1, j=8'hA5, k=8'h00; shadow_state=8'hA5; change_count=4.
- Shadow 8'hA5, target 8'h0F, mask 8'hF0 -> j=8'h0A, k=8'h00; shadow=8'hAF; change_count +2. Then the same vector again -> j=k=0, command_valid=1, count unchanged.
- USE_TOGGLE=1, shadow 8'h00, target 8'h3C -> j=k=8'h3C. Apply the command to a model JK bank; bank equals 8'h3C.
- command_ready=0 for 3 cycles with target_valid=1 -> target_ready=0; j/k/command_valid stable. Ready=1 -> back-to-back targets 8'h01, 8'h03, 8'h02 yield (j,k) = (01,00), (02,00), (00,01) on consecutive cycles.
- sync_valid=1 with sync_state=8'hFF and target_valid=1 the same cycle -> target not accepted; shadow=8'hFF. Next target 8'h00 -> k=8'hFF, j=0.
- COUNTER_WIDTH=4: issue commands totalling more than 15 changed bits -> change_count holds at 4'hF. Assert resetn=0 mid-stream with a pending command -> command_valid=0 immediately; shadow=RESET_VALUE; count=0.

Source files
------------

// File: rtl/jk_command_encoder.sv
// Target-state to J/K command encoder for an external bank of JK flip-flops.
// Tracks a shadow of the bank so each accepted target becomes the minimal set/clear (or toggle) command.
module jk_command_encoder #(
  parameter int                 WIDTH         = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE   = '0,
  parameter int                 USE_TOGGLE    = 0,
  parameter int                 COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     target_valid,
  output logic                     target_ready,
  input  logic [WIDTH-1:0]         target_state,
  input  logic [WIDTH-1:0]         target_mask,
  input  logic                     sync_valid,
  input  logic [WIDTH-1:0]         sync_state,
  output logic                     command_valid,
  input  logic                     command_ready,
  output logic [WIDTH-1:0]         j,
  output logic [WIDTH-1:0]         k,
  output logic [WIDTH-1:0]         shadow_state,
  output logic [COUNTER_WIDTH-1:0] change_count,
  output logic                     idle
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((COUNTER_WIDTH > PC_W) ? COUNTER_WIDTH : PC_W) + 1;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] sat_add(input logic [COUNTER_WIDTH-1:0] a,
                                                       input logic [PC_W-1:0]          b);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] lim;
    sum = SUM_W'(a) + SUM_W'(b);
    lim = SUM_W'({COUNTER_WIDTH{1'b1}});
    if (sum > lim) begin
      return {COUNTER_WIDTH{1'b1}};
    end
    return sum[COUNTER_WIDTH-1:0];
  endfunction

  logic                     r_vld_p1;
  logic [WIDTH-1:0]         r_j_p1;
  logic [WIDTH-1:0]         r_k_p1;
  logic [WIDTH-1:0]         r_shadow;
  logic [COUNTER_WIDTH-1:0] r_count;

  logic                     w_ready;
  logic                     w_accept;
  logic [WIDTH-1:0]         w_change_p0;
  logic [WIDTH-1:0]         w_set_p0;
  logic [WIDTH-1:0]         w_clr_p0;
  logic [WIDTH-1:0]         w_j_p0;
  logic [WIDTH-1:0]         w_k_p0;
  logic [WIDTH-1:0]         w_shadow_next;

  // Stage p0: handshake and per-bit encoding against the shadow
  assign w_ready     = !sync_valid && (!r_vld_p1 || command_ready);
  assign w_accept    = target_valid && w_ready;

  assign w_change_p0 = (target_state ^ r_shadow) & ~target_mask;
  assign w_set_p0    = w_change_p0 & target_state;
  assign w_clr_p0    = w_change_p0 & ~target_state;
  assign w_j_p0      = (USE_TOGGLE != 0) ? w_change_p0 : w_set_p0;
  assign w_k_p0      = (USE_TOGGLE != 0) ? w_change_p0 : w_clr_p0;

  assign w_shadow_next = (target_state & ~target_mask) | (r_shadow & target_mask);

  // Shadow advances at accept time so back-to-back targets see the already-issued command
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_shadow <= RESET_VALUE;
      r_count  <= '0;
    end else if (sync_valid) begin
      r_shadow <= sync_state;
    end else if (w_accept) begin
      r_shadow <= w_shadow_next;
      r_count  <= sat_add(r_count, popcount(w_j_p0 | w_k_p0));
    end
  end

  // Stage p1: registered command, held until consumed, replaced without a bubble
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_vld_p1 <= 1'b0;
      r_j_p1   <= '0;
      r_k_p1   <= '0;
    end else if (w_accept) begin
      r_vld_p1 <= 1'b1;
      r_j_p1   <= w_j_p0;
      r_k_p1   <= w_k_p0;
    end else if (command_ready) begin
      r_vld_p1 <= 1'b0;
      r_j_p1   <= '0;
      r_k_p1   <= '0;
    end
  end

  assign target_ready  = w_ready;
  assign command_valid = r_vld_p1;
  assign j             = r_j_p1;
  assign k             = r_k_p1;
  assign shadow_state  = r_shadow;
  assign change_count  = r_count;
  assign idle          = !r_vld_p1 && !target_valid;

endmodule

// File: tb/tb_jk_command_encoder.sv
// Directed bench for jk_command_encoder: three instances (set/clear, toggle, 4-bit counter) share stimulus.
module tb_jk_command_encoder;

  logic       clock;
  logic       resetn;
  logic       target_valid;
  logic [7:0] target_state;
  logic [7:0] target_mask;
  logic       sync_valid;
  logic [7:0] sync_state;
  logic       command_ready;

  logic        a_rdy, a_vld, a_idle;
  logic [7:0]  a_j, a_k, a_sh;
  logic [15:0] a_cnt;
  logic        b_rdy, b_vld, b_idle;
  logic [7:0]  b_j, b_k, b_sh;
  logic [15:0] b_cnt;
  logic        c_rdy, c_vld, c_idle;
  logic [7:0]  c_j, c_k, c_sh;
  logic [3:0]  c_cnt;

  int checks;
  int failures;
  logic [7:0] bank;

  jk_command_encoder #(.WIDTH(8), .RESET_VALUE(8'h00), .USE_TOGGLE(0), .COUNTER_WIDTH(16)) u_a (
    .clock(clock), .resetn(resetn), .target_valid(target_valid), .target_ready(a_rdy),
    .target_state(target_state), .target_mask(target_mask), .sync_valid(sync_valid),
    .sync_state(sync_state), .command_valid(a_vld), .command_ready(command_ready),
    .j(a_j), .k(a_k), .shadow_state(a_sh), .change_count(a_cnt), .idle(a_idle));

  jk_command_encoder #(.WIDTH(8), .RESET_VALUE(8'h00), .USE_TOGGLE(1), .COUNTER_WIDTH(16)) u_b (
    .clock(clock), .resetn(resetn), .target_valid(target_valid), .target_ready(b_rdy),
    .target_state(target_state), .target_mask(target_mask), .sync_valid(sync_valid),
    .sync_state(sync_state), .command_valid(b_vld), .command_ready(command_ready),
    .j(b_j), .k(b_k), .shadow_state(b_sh), .change_count(b_cnt), .idle(b_idle));

  jk_command_encoder #(.WIDTH(8), .RESET_VALUE(8'h00), .USE_TOGGLE(0), .COUNTER_WIDTH(4)) u_c (
    .clock(clock), .resetn(resetn), .target_valid(target_valid), .target_ready(c_rdy),
    .target_state(target_state), .target_mask(target_mask), .sync_valid(sync_valid),
    .sync_state(sync_state), .command_valid(c_vld), .command_ready(command_ready),
    .j(c_j), .k(c_k), .shadow_state(c_sh), .change_count(c_cnt), .idle(c_idle));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; target_valid = 1'b0; target_state = 8'h00; target_mask = 8'h00;
    sync_valid = 1'b0; sync_state = 8'h00; command_ready = 1'b1;
    tick(); tick();
    checks++; if (a_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", a_vld); end
    checks++; if (a_j !== 8'h00 || a_k !== 8'h00) begin failures++; $display("FAIL reset_jk got=%h/%h exp=00/00", a_j, a_k); end
    checks++; if (a_sh !== 8'h00) begin failures++; $display("FAIL reset_shadow got=%h exp=00", a_sh); end
    checks++; if (a_cnt !== 16'd0 || c_cnt !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0/0", a_cnt, c_cnt); end
    checks++; if (a_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", a_idle); end
    resetn = 1'b1;
  endtask

  task automatic test_encode_basic();
    target_valid = 1'b1; target_state = 8'hA5; target_mask = 8'h00; command_ready = 1'b1;
    #1;
    checks++; if (a_rdy !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", a_rdy); end
    tick();
    checks++; if (a_vld !== 1'b1) begin failures++; $display("FAIL basic_vld got=%b exp=1", a_vld); end
    checks++; if (a_j !== 8'hA5 || a_k !== 8'h00) begin failures++; $display("FAIL basic_jk got=%h/%h exp=a5/00", a_j, a_k); end
    checks++; if (a_sh !== 8'hA5) begin failures++; $display("FAIL basic_shadow got=%h exp=a5", a_sh); end
    checks++; if (a_cnt !== 16'd4) begin failures++; $display("FAIL basic_count got=%0d exp=4", a_cnt); end
    checks++; if (b_j !== 8'hA5 || b_k !== 8'hA5) begin failures++; $display("FAIL basic_toggle_jk got=%h/%h exp=a5/a5", b_j, b_k); end
    // Masked upper nibble: only bits 1 and 3 change
    target_state = 8'h0F; target_mask = 8'hF0;
    tick();
    checks++; if (a_j !== 8'h0A || a_k !== 8'h00) begin failures++; $display("FAIL mask_jk got=%h/%h exp=0a/00", a_j, a_k); end
    checks++; if (a_sh !== 8'hAF) begin failures++; $display("FAIL mask_shadow got=%h exp=af", a_sh); end
    checks++; if (a_cnt !== 16'd6) begin failures++; $display("FAIL mask_count got=%0d exp=6", a_cnt); end
    tick();
    checks++; if (a_vld !== 1'b1 || a_j !== 8'h00 || a_k !== 8'h00) begin failures++; $display("FAIL hold_cmd got=%b %h/%h exp=1 00/00", a_vld, a_j, a_k); end
    checks++; if (a_cnt !== 16'd6 || a_sh !== 8'hAF) begin failures++; $display("FAIL hold_state got=%0d %h exp=6 af", a_cnt, a_sh); end
    target_valid = 1'b0;
    tick();
    checks++; if (a_vld !== 1'b0 || a_j !== 8'h00 || a_idle !== 1'b1) begin failures++; $display("FAIL drain got=%b %h idle=%b exp=0 00 1", a_vld, a_j, a_idle); end
  endtask

  task automatic test_toggle();
    sync_valid = 1'b1; sync_state = 8'h00;
    #1;
    checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL sync_ready got=%b exp=0", a_rdy); end
    tick();
    sync_valid = 1'b0;
    checks++; if (a_sh !== 8'h00 || a_cnt !== 16'd6) begin failures++; $display("FAIL sync_zero got=%h %0d exp=00 6", a_sh, a_cnt); end
    target_valid = 1'b1; target_state = 8'h3C; target_mask = 8'h00;
    tick();
    target_valid = 1'b0; command_ready = 1'b0;
    checks++; if (b_j !== 8'h3C || b_k !== 8'h3C) begin failures++; $display("FAIL toggle_jk got=%h/%h exp=3c/3c", b_j, b_k); end
    bank = 8'h00;
    bank = (b_j & ~bank) | (~b_k & bank);
    checks++; if (bank !== 8'h3C) begin failures++; $display("FAIL toggle_bank got=%h exp=3c", bank); end
    checks++; if (a_j !== 8'h3C || a_k !== 8'h00) begin failures++; $display("FAIL settle_jk got=%h/%h exp=3c/00", a_j, a_k); end
    checks++; if (a_cnt !== 16'd10) begin failures++; $display("FAIL toggle_count got=%0d exp=10", a_cnt); end
  endtask

  task automatic test_back_to_back();
    // Command 3C is pending and stalled; resync to 00 must not disturb it
    target_valid = 1'b1; target_state = 8'h01; target_mask = 8'h00;
    sync_valid = 1'b1; sync_state = 8'h00;
    tick();
    sync_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", n, a_rdy); end
      checks++; if (a_vld !== 1'b1 || a_j !== 8'h3C || a_k !== 8'h00) begin failures++; $display("FAIL stall_cmd cyc=%0d got=%b %h/%h exp=1 3c/00", n, a_vld, a_j, a_k); end
      tick();
    end
    command_ready = 1'b1;
    #1;
    checks++; if (a_rdy !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", a_rdy); end
    tick();
    checks++; if (a_j !== 8'h01 || a_k !== 8'h00) begin failures++; $display("FAIL b2b_1 got=%h/%h exp=01/00", a_j, a_k); end
    target_state = 8'h03;
    tick();
    checks++; if (a_j !== 8'h02 || a_k !== 8'h00) begin failures++; $display("FAIL b2b_2 got=%h/%h exp=02/00", a_j, a_k); end
    target_state = 8'h02;
    tick();
    checks++; if (a_j !== 8'h00 || a_k !== 8'h01 || a_vld !== 1'b1) begin failures++; $display("FAIL b2b_3 got=%h/%h v=%b exp=00/01 1", a_j, a_k, a_vld); end
    checks++; if (a_cnt !== 16'd13 || c_cnt !== 4'd13) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=13/13", a_cnt, c_cnt); end
  endtask

  task automatic test_resync();
    sync_valid = 1'b1; sync_state = 8'hFF; target_valid = 1'b1; target_state = 8'h00;
    #1;
    checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL resync_ready got=%b exp=0", a_rdy); end
    tick();
    sync_valid = 1'b0;
    checks++; if (a_sh !== 8'hFF || a_vld !== 1'b0) begin failures++; $display("FAIL resync_state got=%h v=%b exp=ff 0", a_sh, a_vld); end
    checks++; if (a_cnt !== 16'd13) begin failures++; $display("FAIL resync_count got=%0d exp=13", a_cnt); end
    tick();
    checks++; if (a_j !== 8'h00 || a_k !== 8'hFF) begin failures++; $display("FAIL resync_jk got=%h/%h exp=00/ff", a_j, a_k); end
    checks++; if (a_cnt !== 16'd21 || c_cnt !== 4'hF) begin failures++; $display("FAIL sat_count got=%0d/%0d exp=21/15", a_cnt, c_cnt); end
    target_state = 8'hFF;
    tick();
    command_ready = 1'b0; target_valid = 1'b0;
    checks++; if (a_j !== 8'hFF || a_cnt !== 16'd29 || c_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold got=%h %0d/%0d exp=ff 29/15", a_j, a_cnt, c_cnt); end
  endtask

  task automatic test_reset_midstream();
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (a_vld !== 1'b0 || a_j !== 8'h00 || a_k !== 8'h00) begin failures++; $display("FAIL midreset_cmd got=%b %h/%h exp=0 00/00", a_vld, a_j, a_k); end
    checks++; if (a_sh !== 8'h00 || a_cnt !== 16'd0 || c_cnt !== 4'd0) begin failures++; $display("FAIL midreset_state got=%h %0d/%0d exp=00 0/0", a_sh, a_cnt, c_cnt); end
    tick();
    resetn = 1'b1; command_ready = 1'b1; target_valid = 1'b1; target_state = 8'h5A; target_mask = 8'h00;
    tick();
    target_valid = 1'b0;
    checks++; if (a_j !== 8'h5A || a_k !== 8'h00 || a_cnt !== 16'd4) begin failures++; $display("FAIL post_reset got=%h/%h %0d exp=5a/00 4", a_j, a_k, a_cnt); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_encode_basic();
    test_toggle();
    test_back_to_back();
    test_resync();
    test_reset_midstream();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
